// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// sequencer state encoding and a helper to classify burst-capable operations.
package usr_pkg;

  localparam int MODE_W = 3;
  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_SHL  = 3'd1;
  localparam mode_t MODE_LOAD = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_ROL  = 3'd4;
  localparam mode_t MODE_ROR  = 3'd5;
  localparam mode_t MODE_ASR  = 3'd6;
  localparam mode_t MODE_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only shift and rotate operations can be repeated by the sequencer.
  function automatic logic is_burst_op(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_shift_op.sv
// Combinational next-value function of the register for one operation;
// shared by the direct-mode path and the burst sequencer.
module usr_shift_op
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            op,
  input  logic [WIDTH-1:0] d,
  input  logic             s_in_l,
  input  logic             s_in_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    // NOTE: q_next is assigned on every path (default first, then the case)
    // so no latch can be inferred for unlisted op codes.
    q_next = q;
    case (op)
      MODE_HOLD, MODE_RSVD: q_next = q;
      MODE_SHL:  q_next = {q[WIDTH-2:0], s_in_l};
      MODE_LOAD: q_next = d;
      MODE_SHR:  q_next = {s_in_r, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// WIDTH-bit universal shift register with a burst sequencer that repeats a
// shift/rotate amt times from a single start pulse (busy/done handshake).
module univ_shift_reg_seq
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,   // active-high asynchronous reset
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              s_in_l,
  input  logic              s_in_r,
  input  logic              start,
  input  logic [CNT_W-1:0]  amt,
  output logic [WIDTH-1:0]  q,
  output logic              s_out_l,
  output logic              s_out_r,
  output logic              busy,
  output logic              done
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  mode_t              op_q, op_next;
  mode_t              op_sel;
  logic [WIDTH-1:0]   op_result;
  logic [WIDTH-1:0]   q_next;
  logic [CNT_W-1:0]   amt_sat;

  assign amt_sat = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;

  // While a burst runs the latched op drives the datapath; live mode is ignored.
  assign op_sel = (state == ST_RUN) ? op_q : mode_t'(mode);

  usr_shift_op #(
    .WIDTH (WIDTH)
  ) u_shift_op (
    .q      (q),
    .op     (op_sel),
    .d      (d),
    .s_in_l (s_in_l),
    .s_in_r (s_in_r),
    .q_next (op_result)
  );

  always_comb begin
    state_next = state;
    q_next     = q;
    cnt_next   = cnt;
    op_next    = op_q;

    case (state)
      ST_IDLE: begin
        if (start && is_burst_op(mode_t'(mode))) begin
          op_next = mode_t'(mode);
          if (amt_sat == '0) begin
            state_next = ST_DONE;
          end else begin
            q_next     = op_result;
            cnt_next   = amt_sat - CNT_W'(1);
            state_next = (amt_sat > CNT_W'(1)) ? ST_RUN : ST_DONE;
          end
        end else begin
          q_next = op_result;
        end
      end

      ST_RUN: begin
        q_next   = op_result;
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = ST_DONE;
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_IDLE;
      q     <= '0;
      cnt   <= '0;
      op_q  <= MODE_HOLD;
    end else if (en) begin
      state <= state_next;
      q     <= q_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
    end
  end

  assign s_out_l = q[WIDTH-1];
  assign s_out_r = q[0];
  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Self-checking bench for univ_shift_reg_seq (WIDTH=8): direct-mode vector
// table, hand-written burst corner cases, then random stimulus vs a model.
module tb_univ_shift_reg_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             s_in_l;
  logic             s_in_r;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             s_out_l;
  logic             s_out_r;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  univ_shift_reg_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .s_in_l  (s_in_l),
    .s_in_r  (s_in_r),
    .start   (start),
    .amt     (amt),
    .q       (q),
    .s_out_l (s_out_l),
    .s_out_r (s_out_r),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] m, input logic [7:0] dv, input logic st,
                        input logic [3:0] a);
    mode  = m;
    d     = dv;
    start = st;
    amt   = a;
  endtask

  // ---------------- behavioural model (integer arithmetic) ----------------
  int m_q, m_rem, m_op;
  bit m_done;

  function automatic int apply_op(input int qv, input int op, input int dv,
                                  input int sl, input int sr);
    case (op)
      1:       return (qv * 2 + sl) % 256;
      2:       return dv;
      3:       return qv / 2 + sr * 128;
      4:       return (qv * 2) % 256 + qv / 128;
      5:       return qv / 2 + (qv % 2) * 128;
      6:       return qv / 2 + ((qv >= 128) ? 128 : 0);
      default: return qv;
    endcase
  endfunction

  function automatic bit burst_capable(input int op);
    return op == 1 || op == 3 || op == 4 || op == 5 || op == 6;
  endfunction

  task automatic model_step();
    int n;
    if (!en) return;
    if (m_done) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      m_q = apply_op(m_q, m_op, int'(d), int'(s_in_l), int'(s_in_r));
      m_rem--;
      m_done = (m_rem == 0);
    end else if (start && burst_capable(int'(mode))) begin
      n    = (int'(amt) > WIDTH) ? WIDTH : int'(amt);
      m_op = int'(mode);
      if (n > 0) begin
        m_q   = apply_op(m_q, m_op, int'(d), int'(s_in_l), int'(s_in_r));
        m_rem = n - 1;
      end
      m_done = (m_rem == 0);
    end else begin
      m_q = apply_op(m_q, int'(mode), int'(d), int'(s_in_l), int'(s_in_r));
    end
  endtask

  // ---------------- direct-mode vector table ----------------
  typedef struct {
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int edges;
    logic [7:0] eq;

    vecs[0] = '{3'd2, 8'h81, 1'b0, 1'b0, 8'h81};  // LOAD
    vecs[1] = '{3'd4, 8'h00, 1'b0, 1'b0, 8'h03};  // ROL
    vecs[2] = '{3'd5, 8'h00, 1'b0, 1'b0, 8'h81};  // ROR
    vecs[3] = '{3'd6, 8'h00, 1'b0, 1'b0, 8'hC0};  // ASR
    vecs[4] = '{3'd1, 8'h00, 1'b1, 1'b0, 8'h81};  // SHL, s_in_l=1
    vecs[5] = '{3'd3, 8'hFF, 1'b1, 1'b0, 8'h40};  // SHR, s_in_r=0
    vecs[6] = '{3'd0, 8'hFF, 1'b1, 1'b1, 8'h40};  // HOLD
    vecs[7] = '{3'd7, 8'hFF, 1'b1, 1'b1, 8'h40};  // reserved
    vecs[8] = '{3'd6, 8'h00, 1'b0, 1'b0, 8'h20};  // ASR, sign bit 0

    rst_n = 1'b1; en = 1'b1; s_in_l = 1'b0; s_in_r = 1'b0;
    set_in(3'd0, 8'h00, 1'b0, 4'd0);
    #3;
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b0;
    tick();

    // Asynchronous reset mid-cycle
    set_in(3'd2, 8'hA5, 1'b0, 4'd0);
    tick();
    check("load_a5", q, 32'hA5);
    #2 rst_n = 1'b1;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b0;

    // Direct modes
    foreach (vecs[i]) begin
      set_in(vecs[i].mode, vecs[i].d, 1'b0, 4'd0);
      s_in_l = vecs[i].sl;
      s_in_r = vecs[i].sr;
      tick();
      eq = vecs[i].exp_q;
      check($sformatf("vec%0d_q", i), q, eq);
      check($sformatf("vec%0d_sout", i), {s_out_l, s_out_r}, {eq[7], eq[0]});
      check($sformatf("vec%0d_busy", i), busy, 0);
    end
    s_in_l = 1'b0; s_in_r = 1'b0;

    // Burst SHL x3 from 0x01; mode toggled and start re-asserted during RUN
    set_in(3'd2, 8'h01, 1'b0, 4'd0); tick();
    set_in(3'd1, 8'h00, 1'b1, 4'd3); tick();
    check("b3_e1_q", q, 32'h02);
    check("b3_e1_busy", busy, 1);
    set_in(3'd2, 8'hFF, 1'b1, 4'd1); tick();
    check("b3_e2_q", q, 32'h04);
    check("b3_e2_busy", busy, 1);
    set_in(3'd5, 8'hFF, 1'b0, 4'd0); tick();
    check("b3_e3_q", q, 32'h08);
    check("b3_e3_busy", busy, 0);
    check("b3_e3_done", done, 1);
    set_in(3'd1, 8'h00, 1'b1, 4'd2); tick();  // start during DONE: ignored
    check("b3_e4_q", q, 32'h08);
    check("b3_e4_done", done, 0);
    check("b3_e4_busy", busy, 0);
    set_in(3'd0, 8'h00, 1'b0, 4'd0); tick();
    check("b3_idle_busy", busy, 0);
    check("b3_idle_q", q, 32'h08);

    // amt = 0
    set_in(3'd1, 8'h00, 1'b1, 4'd0); s_in_l = 1'b1; tick();
    check("amt0_q", q, 32'h08);
    check("amt0_done", done, 1);
    check("amt0_busy", busy, 0);
    set_in(3'd0, 8'h00, 1'b0, 4'd0); s_in_l = 1'b0; tick();
    check("amt0_done_clr", done, 0);

    // amt = 15 clamps to 8 rotations
    set_in(3'd2, 8'h01, 1'b0, 4'd0); tick();
    set_in(3'd5, 8'h00, 1'b1, 4'd15); tick();
    set_in(3'd0, 8'h00, 1'b0, 4'd0);
    for (int k = 2; k <= 8; k++) begin
      check($sformatf("amt15_busy_e%0d", k - 1), busy, 1);
      if (k == 5) check("amt15_mid_q", q, 32'h10);
      tick();
    end
    check("amt15_q", q, 32'h01);
    check("amt15_done", done, 1);
    tick();
    check("amt15_done_clr", done, 0);

    // Stall: SHR x4 from 0x80 with s_in_r=1, en low for two mid-run cycles
    set_in(3'd2, 8'h80, 1'b0, 4'd0); tick();
    s_in_r = 1'b1;
    set_in(3'd3, 8'h00, 1'b1, 4'd4); tick();
    set_in(3'd0, 8'h00, 1'b0, 4'd0);
    edges = 1;
    en = 1'b0; tick(); tick(); edges += 2;
    check("stall_q", q, 32'hC0);
    check("stall_busy", busy, 1);
    en = 1'b1;
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
    check("stall_edges", edges, 6);
    check("stall_q_final", q, 32'hF8);
    en = 1'b0; tick();
    check("done_held_en0", done, 1);
    en = 1'b1; tick();
    check("done_clr_en1", done, 0);
    s_in_r = 1'b0;

    // Abort: reset during RUN
    set_in(3'd2, 8'h0F, 1'b0, 4'd0); tick();
    set_in(3'd4, 8'h00, 1'b1, 4'd5); tick();
    set_in(3'd0, 8'h00, 1'b0, 4'd0); tick();
    check("abort_pre_q", q, 32'h3C);
    #2 rst_n = 1'b1;
    #1;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_no_done", done, 0);
    check("abort_busy2", busy, 0);

    // start with LOAD acts as plain load
    set_in(3'd2, 8'h3C, 1'b1, 4'd3); tick();
    check("ldstart_q", q, 32'h3C);
    check("ldstart_busy", busy, 0);
    check("ldstart_done", done, 0);
    set_in(3'd0, 8'h00, 1'b0, 4'd0); tick();
    check("ldstart_done2", done, 0);

    // Random stimulus against the model, from a fresh reset
    rst_n = 1'b1; #1; rst_n = 1'b0;
    m_q = 0; m_rem = 0; m_op = 0; m_done = 0;
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 9) < 8);
      mode   = 3'($urandom_range(0, 7));
      d      = 8'($urandom);
      s_in_l = 1'($urandom);
      s_in_r = 1'($urandom);
      start  = ($urandom_range(0, 3) == 0);
      amt    = 4'($urandom_range(0, 15));
      model_step();
      tick();
      eq = 8'(m_q);
      check($sformatf("rand%0d", i), {q, busy, done, s_out_l, s_out_r},
            {eq, (m_rem > 0), m_done, eq[7], eq[0]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_seq.md
Name: univ_shift_reg_seq

Overview:
Parametrised successor to the 8-bit universal shift register, for use inside tt_um_* wrappers. Supports WIDTH-bit hold, load, logical shift, rotate and arithmetic shift. Adds a burst sequencer: one start pulse performs N consecutive shift or rotate operations with busy/done handshake. Serial taps from both ends allow cascading.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of burst-count input; fixed by formula, not user-set

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset: asynchronous, active-high (1 = reset), despite the codebase name
en  in  1  clock enable; when 0, all state (q, FSM, counter) holds
mode  in  3  operation select (see Behaviour)
d  in  WIDTH  parallel load data
s_in_l  in  1  serial input entering the LSB on shift-left
s_in_r  in  1  serial input entering the MSB on shift-right
start  in  1  burst request (pulse), sampled when en=1
amt  in  CNT_W  burst length in operations, 0..WIDTH
q  out  WIDTH  register contents
s_out_l  out  1  q[WIDTH-1], combinational
s_out_r  out  1  q[0], combinational
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: q=0, busy=0, done=0, FSM=IDLE, counter=0. Reset asserted mid-burst aborts it immediately with no done pulse.
- Mode encoding:
  - 0 HOLD
  - 1 SHL: q <= {q[W-2:0], s_in_l}
  - 2 LOAD: q <= d
  - 3 SHR: q <= {s_in_r, q[W-1:1]}
  - 4 ROL: q <= {q[W-2:0], q[W-1]}
  - 5 ROR: q <= {q[0], q[W-1:1]}
  - 6 ASR: q <= {q[W-1], q[W-1:1]}
  - 7 reserved, behaves as HOLD
- All updates occur on the rising edge of clk with en=1. If en=0, no state changes and done is not asserted.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=0: mode applied every en cycle (direct mode, 1-cycle latency).
- IDLE, start=1, mode in {1,3,4,5,6}:
  - amt>0: apply op this cycle, latch mode, cnt <= amt-1. Go to RUN if amt>1, else DONE.
  - amt=0: no change to q; go to DONE.
- IDLE, start=1, mode in {0,2,7}: start ignored; mode applied as direct op.
- amt > WIDTH is clamped to WIDTH.
- RUN: busy=1. On each en cycle, apply the latched op and decrement cnt. Go to DONE when cnt reaches 0 after the decrement (i.e. the final op). In RUN, mode, start, amt and d are ignored.
- DONE: done=1 for exactly one cycle, busy=0, q held. Next state is IDLE.
  - A start arriving in DONE is ignored; the minimum restart spacing is 1 cycle after done.
  - DONE exits to IDLE only on an en cycle; done remains asserted while en=0.
- Burst of k ops: q reflects all k ops after k en-cycles from start. done is asserted in the following cycle.
- Serial inputs are sampled live each RUN cycle, which allows streaming.

Decomposition:
- Package usr_pkg holds:
  - mode localparams (MODE_HOLD..MODE_ASR, 3-bit)
  - FSM state encoding (IDLE/RUN/DONE, 2-bit)
- Sub-module usr_shift_op: purely combinational next-q function of (q, op, d, s_in_l, s_in_r). It is reused by both direct and burst paths.
- The top level holds the FSM, counter and q register.

Test Plan:
- Reset: drive q via LOAD 0xA5, then assert rst_n=1 asynchronously mid-cycle -> q=0x00, busy=0, done=0 immediately, with no clk edge needed.
- Direct modes: LOAD 0x81, then one cycle each of:
  - ROL -> 0x03
  - ROR -> 0x81
  - ASR -> 0xC0
  - SHL with s_in_l=1 -> 0x81
  - SHR with s_in_r=0 -> 0x40
- Burst: LOAD 0x01; start, mode=SHL, s_in_l=0, amt=3 -> busy high for 2 cycles, q=0x08 after 3 edges, done pulses next cycle, then IDLE. Toggling mode during RUN has no effect.
- Boundaries: start with amt=0 -> q unchanged, done pulse on next cycle. Start with amt=15 on WIDTH=8 ROR from 0x01 -> 8 ops, q=0x01, done.
- Stall and abort:
  - burst with en low for 2 mid-run cycles -> completion delayed by exactly 2 cycles
  - reset during RUN -> q=0, busy=0, no done
- Ignored starts: start with mode=LOAD -> acts as plain load, no busy/done. start during RUN/DONE -> no restart.
